// File: rtl/pc_sequencer.sv
// Program counter and fetch/exec/halt/fault sequencer; resolves branches and jumps,
// with an optional MIPS branch delay slot and an optional bus-wait timeout.
module pc_sequencer #(
   parameter logic [31:0] RESET_VECTOR = 32'hBFC0_0000,
   parameter logic [31:0] HALT_ADDR    = 32'h0000_0000,
   parameter bit          DELAY_SLOT   = 1'b1,
   parameter int unsigned WAIT_TIMEOUT = 0
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic [31:0] i_instruction_word,
   input  logic        i_instr_waitrequest,
   input  logic        i_data_waitrequest,
   input  logic        i_data_access,
   input  logic        i_md_busy,
   input  logic        i_n,
   input  logic        i_z,
   input  logic        i_eq,
   input  logic [31:0] i_read_data_0,
   output logic [31:0] o_instr_address,
   output logic        o_instr_read,
   output logic [1:0]  o_state,
   output logic        o_ir_en,
   output logic        o_commit,
   output logic        o_b_link,
   output logic [31:0] o_link_addr,
   output logic        o_finish,
   output logic        o_fault
);

   typedef enum logic [1:0] {
      StFetch  = 2'b00,
      StExec   = 2'b01,
      StHalted = 2'b10,
      StFault  = 2'b11
   } state_t;

   localparam logic [5:0] OpSpecial = 6'h00;
   localparam logic [5:0] OpRegimm  = 6'h01;
   localparam logic [5:0] OpJ       = 6'h02;
   localparam logic [5:0] OpJal     = 6'h03;
   localparam logic [5:0] OpBeq     = 6'h04;
   localparam logic [5:0] OpBne     = 6'h05;
   localparam logic [5:0] OpBlez    = 6'h06;
   localparam logic [5:0] OpBgtz    = 6'h07;
   localparam logic [5:0] FnJr      = 6'h08;
   localparam logic [5:0] FnJalr    = 6'h09;
   localparam logic [4:0] RtBltz    = 5'h00;
   localparam logic [4:0] RtBgez    = 5'h01;
   localparam logic [4:0] RtBltzal  = 5'h10;
   localparam logic [4:0] RtBgezal  = 5'h11;

   state_t      r_state;
   logic [31:0] r_pc;
   logic [31:0] r_pending_target;
   logic        r_pending_valid;
   logic [31:0] r_wait_cnt;

   logic [5:0]  w_opcode;
   logic [5:0]  w_funct;
   logic [4:0]  w_rt;
   logic [31:0] w_pc4;
   logic [31:0] w_br_target;
   logic [31:0] w_j_target;
   logic [31:0] w_target;
   logic        w_redirect;
   logic        w_link;
   logic        w_is_jr;
   logic        w_take;
   logic        w_misaligned;
   logic        w_stall;
   logic        w_waiting;
   logic        w_timeout;
   logic        w_commit;
   logic [31:0] w_next_pc;

   assign w_opcode    = i_instruction_word[31:26];
   assign w_funct     = i_instruction_word[5:0];
   assign w_rt        = i_instruction_word[20:16];
   assign w_pc4       = r_pc + 32'd4;
   assign w_br_target = w_pc4 + {{14{i_instruction_word[15]}}, i_instruction_word[15:0], 2'b00};
   assign w_j_target  = {w_pc4[31:28], i_instruction_word[25:0], 2'b00};

   // w_redirect is the taken condition; w_link ignores the condition.
   always_comb begin
      w_redirect = 1'b0;
      w_link     = 1'b0;
      w_is_jr    = 1'b0;
      w_target   = w_br_target;
      case (w_opcode)
         OpSpecial: begin
            if (w_funct == FnJr || w_funct == FnJalr) begin
               w_redirect = 1'b1;
               w_is_jr    = 1'b1;
               w_target   = i_read_data_0;
               w_link     = (w_funct == FnJalr);
            end
         end
         OpRegimm: begin
            case (w_rt)
               RtBltz:   w_redirect = i_n;
               RtBgez:   w_redirect = !i_n;
               RtBltzal: begin w_redirect = i_n;  w_link = 1'b1; end
               RtBgezal: begin w_redirect = !i_n; w_link = 1'b1; end
               default:  ;
            endcase
         end
         OpJ:     begin w_redirect = 1'b1; w_target = w_j_target; end
         OpJal:   begin w_redirect = 1'b1; w_target = w_j_target; w_link = 1'b1; end
         OpBeq:   w_redirect = i_eq;
         OpBne:   w_redirect = !i_eq;
         OpBlez:  w_redirect = i_n | i_z;
         OpBgtz:  w_redirect = !i_n & !i_z;
         default: ;
      endcase
   end

   // A redirect sitting in a delay slot behaves as straight-line code.
   assign w_take       = w_redirect & !(DELAY_SLOT & r_pending_valid);
   assign w_misaligned = w_is_jr & w_take & (w_target[1:0] != 2'b00);
   assign w_stall      = i_md_busy | (i_data_access & i_data_waitrequest);
   assign w_waiting    = ((r_state == StFetch) & i_instr_waitrequest) |
                         ((r_state == StExec) & i_data_access & i_data_waitrequest);
   assign w_timeout    = (WAIT_TIMEOUT != 0) && w_waiting &&
                         (r_wait_cnt + 32'd1 == WAIT_TIMEOUT);
   assign w_commit     = (r_state == StExec) & !w_stall & !i_reset;

   always_comb begin
      if (DELAY_SLOT) begin
         w_next_pc = r_pending_valid ? r_pending_target : w_pc4;
      end else begin
         w_next_pc = w_take ? w_target : w_pc4;
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         r_state          <= StFetch;
         r_pc             <= RESET_VECTOR;
         r_pending_target <= '0;
         r_pending_valid  <= 1'b0;
         r_wait_cnt       <= '0;
      end else begin
         r_wait_cnt <= w_waiting ? r_wait_cnt + 32'd1 : '0;
         case (r_state)
            StFetch: begin
               if (w_timeout) begin
                  r_state <= StFault;
               end else if (!i_instr_waitrequest) begin
                  r_state <= StExec;
               end
            end
            StExec: begin
               if (w_timeout) begin
                  r_state <= StFault;
               end else if (w_commit) begin
                  if (w_misaligned) begin
                     r_pc            <= w_target;
                     r_pending_valid <= 1'b0;
                     r_state         <= StFault;
                  end else begin
                     r_pc    <= w_next_pc;
                     r_state <= (w_next_pc == HALT_ADDR) ? StHalted : StFetch;
                     if (DELAY_SLOT) begin
                        if (r_pending_valid) begin
                           r_pending_valid <= 1'b0;
                        end else if (w_redirect) begin
                           r_pending_valid  <= 1'b1;
                           r_pending_target <= w_target;
                        end
                     end
                  end
               end
            end
            default: ;
         endcase
      end
   end

   assign o_instr_address = r_pc;
   assign o_instr_read    = (r_state == StFetch);
   assign o_state         = r_state;
   assign o_ir_en         = (r_state == StFetch) & !i_instr_waitrequest & !i_reset;
   assign o_commit        = w_commit;
   assign o_b_link        = (r_state == StExec) & w_link;
   assign o_link_addr     = DELAY_SLOT ? r_pc + 32'd8 : r_pc + 32'd4;
   assign o_finish        = (r_state == StHalted);
   assign o_fault         = (r_state == StFault);

endmodule

// File: tb/tb_pc_sequencer.sv
// Randomised scoreboard bench for pc_sequencer: one delay-slot instance and one
// no-delay-slot instance with a 4-cycle wait timeout, both fed the same stimulus.
module tb_pc_sequencer;
   localparam logic [31:0] RV   = 32'hBFC0_0000;
   localparam logic [31:0] NOP  = 32'h0000_0000;
   localparam logic [31:0] JR0  = {6'h00, 5'd4, 15'd0, 6'h08};
   localparam logic [31:0] JALR = {6'h00, 5'd4, 5'd0, 5'd31, 5'd0, 6'h09};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, iwr, dwr, dacc, md, n, z, eq;
   logic [31:0] iw, rd0;
   logic [31:0] addr1, addr0, link1, link0;
   logic [1:0]  st1, st0;
   logic        read1, read0, iren1, iren0, com1, com0, bl1, bl0, fin1, fin0, flt1, flt0;

   pc_sequencer #(.RESET_VECTOR(RV), .HALT_ADDR(32'h0), .DELAY_SLOT(1'b1), .WAIT_TIMEOUT(0)) u_ds1 (
      .i_clk(clk), .i_reset(rst), .i_instruction_word(iw), .i_instr_waitrequest(iwr),
      .i_data_waitrequest(dwr), .i_data_access(dacc), .i_md_busy(md), .i_n(n), .i_z(z),
      .i_eq(eq), .i_read_data_0(rd0), .o_instr_address(addr1), .o_instr_read(read1),
      .o_state(st1), .o_ir_en(iren1), .o_commit(com1), .o_b_link(bl1), .o_link_addr(link1),
      .o_finish(fin1), .o_fault(flt1));

   pc_sequencer #(.RESET_VECTOR(RV), .HALT_ADDR(32'h0), .DELAY_SLOT(1'b0), .WAIT_TIMEOUT(4)) u_ds0 (
      .i_clk(clk), .i_reset(rst), .i_instruction_word(iw), .i_instr_waitrequest(iwr),
      .i_data_waitrequest(dwr), .i_data_access(dacc), .i_md_busy(md), .i_n(n), .i_z(z),
      .i_eq(eq), .i_read_data_0(rd0), .o_instr_address(addr0), .o_instr_read(read0),
      .o_state(st0), .o_ir_en(iren0), .o_commit(com0), .o_b_link(bl0), .o_link_addr(link0),
      .o_finish(fin0), .o_fault(flt0));

   typedef struct {logic [31:0] addr; int unsigned cyc;} fetch_t;
   typedef struct {logic link; logic [31:0] laddr; int unsigned cyc;} commit_t;

   fetch_t      qf1[$], qf0[$];
   commit_t     qc1[$], qc0[$];
   fetch_t      mf;
   commit_t     mc;
   int unsigned cyc = 0;
   int          checks = 0, errors = 0;
   bit          sb_en = 1'b0;

   // Instruction-level reference: (pc, npc) pair for the delay-slot machine.
   logic [31:0] m1_pc, m1_npc, m0_pc;
   bit          m1_slot, m1_halt, m0_halt;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h, required %h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   always @(negedge clk) begin
      if (sb_en) begin
         if (iren1) begin
            if (qf1.size() == 0) begin
               checks++; errors++;
               $display("FAIL ds1 fetch: unexpected ir_en at %h, none required", addr1);
            end else begin
               mf = qf1.pop_front();
               check("ds1 fetch addr", addr1, mf.addr);
               check("ds1 fetch cycle", cyc, mf.cyc);
               check("ds1 instr_read", 32'(read1), 32'd1);
            end
         end
         if (com1) begin
            if (qc1.size() == 0) begin
               checks++; errors++;
               $display("FAIL ds1 commit: unexpected commit, none required");
            end else begin
               mc = qc1.pop_front();
               check("ds1 commit cycle", cyc, mc.cyc);
               check("ds1 b_link", 32'(bl1), 32'(mc.link));
               check("ds1 link_addr", link1, mc.laddr);
            end
         end
         if (iren0) begin
            if (qf0.size() == 0) begin
               checks++; errors++;
               $display("FAIL ds0 fetch: unexpected ir_en at %h, none required", addr0);
            end else begin
               mf = qf0.pop_front();
               check("ds0 fetch addr", addr0, mf.addr);
               check("ds0 fetch cycle", cyc, mf.cyc);
               check("ds0 instr_read", 32'(read0), 32'd1);
            end
         end
         if (com0) begin
            if (qc0.size() == 0) begin
               checks++; errors++;
               $display("FAIL ds0 commit: unexpected commit, none required");
            end else begin
               mc = qc0.pop_front();
               check("ds0 commit cycle", cyc, mc.cyc);
               check("ds0 b_link", 32'(bl0), 32'(mc.link));
               check("ds0 link_addr", link0, mc.laddr);
            end
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic fetch_noise();
      md   = 1'($urandom);
      dacc = 1'($urandom);
      dwr  = 1'($urandom);
   endtask

   task automatic do_reset();
      rst = 1'b1; iwr = 1'b1; md = 1'b0; dacc = 1'b0; dwr = 1'b0;
      n = 1'b0; z = 1'b0; eq = 1'b0; iw = NOP; rd0 = 32'h0;
      tick();
      tick();
      rst = 1'b0;
      m1_pc = RV; m1_npc = RV + 32'd4; m1_slot = 1'b0; m1_halt = 1'b0;
      m0_pc = RV; m0_halt = 1'b0;
   endtask

   // Architectural branch/jump outcome of one instruction at address pc.
   task automatic resolve(input logic [31:0] w, input logic [31:0] pc, input logic vn, vz, veq,
                          input logic [31:0] vrd0, output bit redir, output bit link,
                          output logic [31:0] tgt);
      logic [31:0] pc4;
      pc4   = pc + 32'd4;
      redir = 1'b0;
      link  = 1'b0;
      tgt   = pc4 + {{14{w[15]}}, w[15:0], 2'b00};
      case (w[31:26])
         6'h00: if (w[5:0] == 6'h08 || w[5:0] == 6'h09) begin
                   redir = 1'b1; tgt = vrd0; link = (w[5:0] == 6'h09);
                end
         6'h01: case (w[20:16])
                   5'h00:   redir = vn;
                   5'h01:   redir = !vn;
                   5'h10:   begin redir = vn;  link = 1'b1; end
                   5'h11:   begin redir = !vn; link = 1'b1; end
                   default: ;
                endcase
         6'h02: begin redir = 1'b1; tgt = {pc4[31:28], w[25:0], 2'b00}; end
         6'h03: begin redir = 1'b1; tgt = {pc4[31:28], w[25:0], 2'b00}; link = 1'b1; end
         6'h04: redir = veq;
         6'h05: redir = !veq;
         6'h06: redir = vn | vz;
         6'h07: redir = !vn && !vz;
         default: ;
      endcase
   endtask

   // Jump targets stay inside 0x004xxxxx / 0x?8-0x?B region so random code never halts.
   function automatic logic [31:0] rand_instr();
      logic [31:0] w, r;
      logic [4:0]  rt;
      w = $urandom;
      case ($urandom_range(0, 4))
         0: rt = 5'h00; 1: rt = 5'h01; 2: rt = 5'h10; 3: rt = 5'h11; default: rt = 5'h05;
      endcase
      case ($urandom_range(0, 11))
         0:       r = {6'h00, w[25:6], 6'h08};
         1:       r = {6'h00, w[25:6], 6'h09};
         2:       r = {6'h00, w[25:6], 6'h20};
         3:       r = {6'h01, w[25:21], rt, w[15:0]};
         4:       r = {6'h02, 2'b10, w[23:0]};
         5:       r = {6'h03, 2'b10, w[23:0]};
         6:       r = {6'h04, w[25:0]};
         7:       r = {6'h05, w[25:0]};
         8:       r = {6'h06, w[25:0]};
         9:       r = {6'h07, w[25:0]};
         default: r = {6'h23, w[25:0]};
      endcase
      return r;
   endfunction

   task automatic issue(input logic [31:0] instr, input logic vn, vz, veq,
                        input logic [31:0] vrd0, input int fw, input int sw);
      bit          r1, r0, lk;
      logic [31:0] t1, t0, p;
      int          sel;
      fetch_t      ef;
      commit_t     ec;
      for (int k = 0; k < fw; k++) begin
         iwr = 1'b1; fetch_noise(); tick();
      end
      iwr = 1'b0; fetch_noise();
      iw = instr; n = vn; z = vz; eq = veq; rd0 = vrd0;
      ef.cyc = cyc;
      if (!m1_halt) begin ef.addr = m1_pc; qf1.push_back(ef); end
      if (!m0_halt) begin ef.addr = m0_pc; qf0.push_back(ef); end
      tick();
      // At most three consecutive data-wait cycles keep the timeout instance alive.
      for (int k = 0; k < sw; k++) begin
         iwr = 1'($urandom);
         if (k < 3 && $urandom_range(0, 1) == 1) begin
            md = 1'b0; dacc = 1'b1; dwr = 1'b1;
         end else begin
            sel = $urandom_range(0, 2);
            md = 1'b1; dacc = (sel == 1); dwr = (sel == 2);
         end
         tick();
      end
      sel = $urandom_range(0, 2);
      iwr = 1'($urandom); md = 1'b0; dacc = (sel == 1); dwr = (sel == 2);
      ec.cyc = cyc;
      resolve(instr, m1_pc, vn, vz, veq, vrd0, r1, lk, t1);
      resolve(instr, m0_pc, vn, vz, veq, vrd0, r0, lk, t0);
      ec.link = lk;
      if (!m1_halt) begin
         ec.laddr = m1_pc + 32'd8;
         qc1.push_back(ec);
         p = m1_npc;
         if (r1 && !m1_slot) begin m1_npc = t1; m1_slot = 1'b1; end
         else begin m1_npc = p + 32'd4; m1_slot = 1'b0; end
         m1_pc = p;
         m1_halt = (p == 32'h0);
      end
      if (!m0_halt) begin
         ec.laddr = m0_pc + 32'd4;
         qc0.push_back(ec);
         m0_pc = r0 ? t0 : m0_pc + 32'd4;
         m0_halt = (m0_pc == 32'h0);
      end
      tick();
   endtask

   initial begin
      do_reset();
      #1;
      check("reset state ds1", 32'(st1), 32'd0);
      check("reset state ds0", 32'(st0), 32'd0);
      check("reset addr ds1", addr1, RV);
      check("reset addr ds0", addr0, RV);
      check("reset read ds1", 32'(read1), 32'd1);
      check("reset flags ds1", {29'd0, fin1, flt1, com1}, 32'd0);
      check("reset flags ds0", {29'd0, fin0, flt0, com0}, 32'd0);
      sb_en = 1'b1;

      // beq taken, imm=3, at the reset vector
      issue({6'h04, 5'd1, 5'd2, 16'd3}, 1'b0, 1'b0, 1'b1, 32'h0, 0, 0);
      for (int i = 0; i < 300; i++) begin
         issue(rand_instr(), 1'($urandom), 1'($urandom), 1'($urandom),
               32'h0040_0000 | ($urandom & 32'h000F_FFFC),
               $urandom_range(0, 3), $urandom_range(0, 5));
      end

      // jr to HALT_ADDR followed by a nop
      issue(NOP, 1'b0, 1'b0, 1'b0, 32'h0, 0, 0);
      issue(JR0, 1'b0, 1'b0, 1'b0, 32'h0, 1, 2);
      issue(NOP, 1'b0, 1'b0, 1'b0, 32'h0, 0, 0);
      for (int k = 0; k < 4; k++) begin
         iwr = 1'b0; fetch_noise(); tick();
      end
      check("fetch queue drained ds1", qf1.size(), 32'd0);
      check("fetch queue drained ds0", qf0.size(), 32'd0);
      check("commit queue drained ds1", qc1.size(), 32'd0);
      check("commit queue drained ds0", qc0.size(), 32'd0);
      check("halt state ds1", 32'(st1), 32'd2);
      check("halt state ds0", 32'(st0), 32'd2);
      check("halt finish/read ds1", {30'd0, fin1, read1}, 32'd2);
      check("halt finish/read ds0", {30'd0, fin0, read0}, 32'd2);
      check("halt addr ds1", addr1, 32'h0);
      sb_en = 1'b0;

      // md_busy for 5 cycles delays the commit
      do_reset();
      iwr = 1'b0; tick();
      iw = NOP; md = 1'b1;
      for (int k = 0; k < 5; k++) begin
         #1;
         check("md stall commit ds1", 32'(com1), 32'd0);
         check("md stall commit ds0", 32'(com0), 32'd0);
         tick();
      end
      md = 1'b0;
      #1;
      check("md release commit ds1", 32'(com1), 32'd1);
      check("md release commit ds0", 32'(com0), 32'd1);
      tick();
      #1;
      check("after nop addr ds1", addr1, RV + 32'd4);
      check("after nop addr ds0", addr0, RV + 32'd4);

      // reset while stalled in EXEC
      iwr = 1'b0; tick();
      md = 1'b1; tick();
      rst = 1'b1; tick();
      rst = 1'b0;
      #1;
      check("mid-stall reset state ds1", 32'(st1), 32'd0);
      check("mid-stall reset addr ds1", addr1, RV);
      check("mid-stall reset addr ds0", addr0, RV);

      // jalr to a misaligned target
      iwr = 1'b0; md = 1'b0; tick();
      iw = JALR; rd0 = 32'h0040_0002;
      #1;
      check("jalr b_link ds1", 32'(bl1), 32'd1);
      check("jalr b_link ds0", 32'(bl0), 32'd1);
      check("jalr link_addr ds1", link1, RV + 32'd8);
      check("jalr link_addr ds0", link0, RV + 32'd4);
      tick();
      #1;
      check("jalr fault state ds1", 32'(st1), 32'd3);
      check("jalr fault state ds0", 32'(st0), 32'd3);
      check("jalr fault/read ds1", {30'd0, flt1, read1}, 32'd2);
      check("jalr fault addr ds1", addr1, 32'h0040_0002);
      check("jalr fault addr ds0", addr0, 32'h0040_0002);

      // instr_waitrequest stuck high
      do_reset();
      for (int k = 0; k < 4; k++) begin
         #1;
         check("timeout pending state ds0", 32'(st0), 32'd0);
         tick();
      end
      #1;
      check("timeout state ds0", 32'(st0), 32'd3);
      check("timeout fault ds0", 32'(flt0), 32'd1);
      check("no-timeout state ds1", 32'(st1), 32'd0);
      check("no-timeout addr ds1", addr1, RV);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
